// File: rtl/msp430_wakeup_gate.sv
// Wakeup combiner: synchronises and edge-detects NCH async requests into sticky
// pending flags, then drives one registered wakeup pulse with a minimum high time.
`timescale 1ns/1ps

module msp430_wakeup_gate #(
  parameter  int NCH         = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int HOLD_CYCLES = 4,
  localparam int ID_W        = (NCH == 1) ? 1 : $clog2(NCH)
) (
  input  logic            mclk,
  input  logic            reset_n,
  input  logic [NCH-1:0]  wkup_req,
  input  logic [NCH-1:0]  wkup_en,
  input  logic [NCH-1:0]  wkup_clr,
  output logic [NCH-1:0]  wkup_pend,
  output logic [ID_W-1:0] wkup_id,
  output logic            wkup_out
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_r;
  logic [NCH-1:0]                  sync_s;
  logic [NCH-1:0]                  prev_r;
  logic [NCH-1:0]                  rise_r;
  logic [NCH-1:0]                  pend_r;
  logic [NCH-1:0]                  qual_s;
  logic                            active_s;
  logic [ID_W-1:0]                 id_s;
  state_t                          state_r;
  state_t                          state_nxt_s;
  logic [7:0]                      cnt_r;
  logic [7:0]                      cnt_nxt_s;
  logic                            out_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Request synchroniser chain, edge history and registered rising-edge strobe
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      prev_r <= '0;
      rise_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], wkup_req};
      prev_r <= sync_s;
      rise_r <= sync_s & ~prev_r;
    end
  end

  // Sticky pending flags; a coincident set beats the clear
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r <= '0;
    end else begin
      pend_r <= (pend_r & ~wkup_clr) | rise_r;
    end
  end

  assign qual_s   = pend_r & wkup_en;
  assign active_s = |qual_s;

  // Lowest qualified channel index; scanning downward lets the lowest one win
  always_comb begin
    id_s = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      id_s = qual_s[i] ? ID_W'(i) : id_s;
    end
  end

  // Next-state and hold-counter logic for the output pulse shaper
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (active_s) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = HOLD_LOAD;
        end else begin
          cnt_nxt_s   = 8'd0;
        end
      end
      ST_HOLD: begin
        if (cnt_r != 8'd0) begin
          cnt_nxt_s   = cnt_r - 8'd1;
        end else if (active_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!active_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, counter and output flop; wkup_out is decoded ahead of the edge so it
  // comes directly from a register
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      out_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      out_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  assign wkup_pend = pend_r;
  assign wkup_id   = id_s;
  assign wkup_out  = out_r;

endmodule

// File: tb/tb_msp430_wakeup_gate.sv
// Self-checking bench for msp430_wakeup_gate: directed scenarios plus random
// stress against an edge-indexed behavioural model.
`timescale 1ns/1ps

module tb_msp430_wakeup_gate;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int ID_W = 2;

  logic            mclk;
  logic            reset_n;
  logic [NCH-1:0]  wkup_req;
  logic [NCH-1:0]  wkup_en;
  logic [NCH-1:0]  wkup_clr;
  logic [NCH-1:0]  wkup_pend;
  logic [ID_W-1:0] wkup_id;
  logic            wkup_out;

  int n_checks = 0;
  int n_fail   = 0;

  msp430_wakeup_gate #(.NCH(NCH), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .wkup_req  (wkup_req),
    .wkup_en   (wkup_en),
    .wkup_clr  (wkup_clr),
    .wkup_pend (wkup_pend),
    .wkup_id   (wkup_id),
    .wkup_out  (wkup_out)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Reference model: hist[k] is the request sampled k+1 edges ago. A request
  // first sampled at edge n sets pending at edge n+SYNC+1; the pulse is high
  // at least HOLD edges and then until nothing qualified is pending.
  logic [NCH-1:0] hist [0:SYNC+1];
  logic [NCH-1:0] m_pend = '0;
  logic           m_out  = 1'b0;
  int             m_len  = 0;

  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= SYNC + 1; k++) hist[k] <= '0;
      m_pend <= '0;
      m_out  <= 1'b0;
      m_len  <= 0;
    end else begin
      hist[0] <= wkup_req;
      for (int k = 1; k <= SYNC + 1; k++) hist[k] <= hist[k-1];
      m_pend <= (m_pend & ~wkup_clr) | (hist[SYNC] & ~hist[SYNC+1]);
      if (!m_out) begin
        if (|(m_pend & wkup_en)) begin
          m_out <= 1'b1;
          m_len <= 1;
        end
      end else if (m_len < HOLD) begin
        m_len <= m_len + 1;
      end else if (!(|(m_pend & wkup_en))) begin
        m_out <= 1'b0;
      end
    end
  end

  function automatic int ref_id(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    wkup_req = '0;
    wkup_en  = '0;
    wkup_clr = '0;
    repeat (3) step();
    n_checks++;
    if (wkup_out !== 1'b0 || wkup_pend !== 4'b0000 || wkup_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: out=%b pend=%b id=%0d, expected 0/0000/0", wkup_out, wkup_pend, wkup_id);
    end
    reset_n = 1'b1;
    step();
    n_checks++;
    if (wkup_out !== 1'b0 || wkup_pend !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: out=%b pend=%b, expected 0/0000", wkup_out, wkup_pend);
    end
  endtask

  task automatic test_latency();
    wkup_en  = 4'b0010;
    wkup_req = 4'b0010;
    for (int e = 0; e <= 4; e++) begin
      step();
      n_checks++;
      if (wkup_pend !== ((e >= 3) ? 4'b0010 : 4'b0000) || wkup_out !== (e >= 4)) begin
        n_fail++;
        $display("FAIL latency_edge%0d: pend=%b out=%b", e, wkup_pend, wkup_out);
      end
    end
    n_checks++;
    if (wkup_id !== 2'd1) begin
      n_fail++;
      $display("FAIL latency_id: got %0d expected 1", wkup_id);
    end
  endtask

  task automatic test_hold_clear();
    wkup_clr = 4'b0010;
    for (int e = 5; e <= 9; e++) begin
      step();
      wkup_clr = '0;
      n_checks++;
      if (wkup_out !== (e <= 7) || wkup_pend !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold_len_edge%0d: out=%b pend=%b expected out=%b pend=0000", e, wkup_out, wkup_pend, (e <= 7));
      end
    end
    wkup_req = '0;
    wkup_en  = '0;
    repeat (4) step();
  endtask

  task automatic test_late_enable();
    wkup_req = 4'b0100;
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e == 2) wkup_req = '0;
      n_checks++;
      if (wkup_pend !== ((e >= 3) ? 4'b0100 : 4'b0000) || wkup_out !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_pend_edge%0d: pend=%b out=%b", e, wkup_pend, wkup_out);
      end
    end
    wkup_en = 4'b0100;
    for (int e = 7; e <= 16; e++) begin
      step();
      n_checks++;
      if (wkup_out !== 1'b1 || wkup_id !== 2'd2) begin
        n_fail++;
        $display("FAIL enable_wake_edge%0d: out=%b id=%0d expected 1/2", e, wkup_out, wkup_id);
      end
    end
    wkup_clr = 4'b0100;
    step();
    wkup_clr = '0;
    n_checks++;
    if (wkup_pend !== 4'b0000 || wkup_out !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_clear: pend=%b out=%b expected 0000/1", wkup_pend, wkup_out);
    end
    step();
    n_checks++;
    if (wkup_out !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_fall: out=%b expected 0", wkup_out);
    end
    wkup_en = '0;
    repeat (2) step();
  endtask

  task automatic test_set_wins_and_id();
    wkup_en  = 4'b1001;
    wkup_req = 4'b1001;
    repeat (3) step();
    wkup_clr = 4'b1000;
    step();
    wkup_clr = '0;
    n_checks++;
    if (wkup_pend !== 4'b1001 || wkup_id !== 2'd0) begin
      n_fail++;
      $display("FAIL set_wins: pend=%b id=%0d expected 1001/0", wkup_pend, wkup_id);
    end
    wkup_clr = 4'b0001;
    step();
    wkup_clr = '0;
    n_checks++;
    if (wkup_pend !== 4'b1000 || wkup_id !== 2'd3) begin
      n_fail++;
      $display("FAIL id_after_clear: pend=%b id=%0d expected 1000/3", wkup_pend, wkup_id);
    end
    wkup_clr = 4'b1000;
    wkup_req = '0;
    step();
    wkup_clr = '0;
    repeat (10) step();
    n_checks++;
    if (wkup_out !== 1'b0 || wkup_pend !== 4'b0000) begin
      n_fail++;
      $display("FAIL settle_idle: out=%b pend=%b", wkup_out, wkup_pend);
    end
    wkup_en = '0;
  endtask

  task automatic test_async_reset();
    wkup_en  = 4'b0001;
    wkup_req = 4'b0001;
    repeat (6) step();
    n_checks++;
    if (wkup_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: out=%b expected 1", wkup_out);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (wkup_out !== 1'b0 || wkup_pend !== 4'b0000 || wkup_id !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: out=%b pend=%b id=%0d expected 0/0000/0", wkup_out, wkup_pend, wkup_id);
    end
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
    for (int e = 0; e <= 3; e++) begin
      step();
      n_checks++;
      if (wkup_pend[0] !== (e >= 3)) begin
        n_fail++;
        $display("FAIL reset_release_edge%0d: pend0=%b expected %b", e, wkup_pend[0], (e >= 3));
      end
    end
    wkup_req = '0;
    wkup_clr = 4'b0001;
    step();
    wkup_clr = '0;
    repeat (8) step();
  endtask

  task automatic test_random_stress();
    logic [ID_W-1:0] exp_id;
    logic prev_out = 1'b0;
    bit   seen_low = 1'b0;
    int   hi = 0;
    int   lo = 0;
    for (int c = 0; c < 10000; c++) begin
      step();
      exp_id = ID_W'(ref_id(m_pend & wkup_en));
      n_checks++;
      if (wkup_pend !== m_pend || wkup_out !== m_out || wkup_id !== exp_id) begin
        n_fail++;
        $display("FAIL stress_model c=%0d: pend=%b out=%b id=%0d expected %b/%b/%0d",
                 c, wkup_pend, wkup_out, wkup_id, m_pend, m_out, exp_id);
      end
      if (wkup_out && !prev_out) begin
        n_checks++;
        if (seen_low && lo < 1) begin
          n_fail++;
          $display("FAIL stress_gap c=%0d: low %0d cycles", c, lo);
        end
        hi = 1;
      end else if (wkup_out) begin
        hi++;
      end else if (prev_out) begin
        n_checks++;
        if (hi < HOLD) begin
          n_fail++;
          $display("FAIL stress_width c=%0d: high %0d cycles, minimum %0d", c, hi, HOLD);
        end
        lo = 1;
        seen_low = 1'b1;
      end else begin
        lo++;
        seen_low = 1'b1;
      end
      prev_out = wkup_out;
      if (c % 2 == 0) begin
        for (int i = 0; i < NCH; i++) if ($urandom_range(3) == 0) wkup_req[i] = ~wkup_req[i];
      end
      if ($urandom_range(7) == 0) wkup_en = NCH'($urandom);
      for (int i = 0; i < NCH; i++) wkup_clr[i] = ($urandom_range(15) == 0);
    end
    wkup_req = '0;
    wkup_clr = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold_clear();
    test_late_enable();
    test_set_wins_and_id();
    test_async_reset();
    test_random_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
